// File: rtl/byte_sub_shift_row_pkg.sv
// Shared AES widths and the ShiftRows byte-index mapping for the SubBytes/ShiftRows stage.
package byte_sub_shift_row_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NB      = 4;
  localparam int AES_ROUND_W = 4;
  localparam int AES_NBYTES  = AES_BLOCK_W / AES_BYTE_W;

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] blk;
    logic [AES_ROUND_W-1:0] rnd;
  } stage_dat_t;

  // Output byte k = 4c+r takes substituted byte s[r][(c+r) mod 4] (column-major byte order).
  function automatic int shift_row_src(input int k);
    int r;
    int c;
    r = k % AES_NB;
    c = k / AES_NB;
    return AES_NB * ((c + r) % AES_NB) + r;
  endfunction

endpackage

// File: rtl/byte_sub_shift_row_sbox.sv
// AES forward S-box, purely combinational 256-entry lookup; entry 0 sits in the top byte.
module sBox
  import byte_sub_shift_row_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] i_byte,
  output logic [AES_BYTE_W-1:0] o_byte
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x occupies bits [2047-8x -: 8], and 2047-8x == {~x, 3'b111}.
  assign o_byte = SBOX_TBL[{~i_byte, 3'b111} -: 8];

endmodule

// File: rtl/byte_sub_shift_row.sv
// AES SubBytes+ShiftRows: S1 input register, S-box/shift logic, S2 output register; 2-cycle latency.
// Valid/ready both sides; oReady is the only combinational path (from iReady), full pipe stalls upstream.
module byte_sub_shift_row
  import byte_sub_shift_row_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [AES_BLOCK_W-1:0] iBlockIn,
  input  logic [AES_ROUND_W-1:0] iRound,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [AES_BLOCK_W-1:0] oBlockout,
  output logic [AES_ROUND_W-1:0] oRound
);

  logic       r_s1_vld;
  logic       r_s2_vld;
  stage_dat_t r_s1_dat;
  stage_dat_t r_s2_dat;

  logic                   w_s2_adv;
  logic                   w_s1_adv;
  logic [AES_BLOCK_W-1:0] w_sub;
  logic [AES_BLOCK_W-1:0] w_shift;

  assign w_s2_adv = !r_s2_vld || iReady;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;
  assign oReady   = w_s1_adv;

  for (genvar k = 0; k < AES_NBYTES; k++) begin : g_byte
    localparam int SRC = shift_row_src(k);

    sBox u_sbox (
      .i_byte (r_s1_dat.blk[AES_BLOCK_W-1-AES_BYTE_W*k -: AES_BYTE_W]),
      .o_byte (w_sub[AES_BLOCK_W-1-AES_BYTE_W*k -: AES_BYTE_W])
    );

    assign w_shift[AES_BLOCK_W-1-AES_BYTE_W*k -: AES_BYTE_W] =
      w_sub[AES_BLOCK_W-1-AES_BYTE_W*SRC -: AES_BYTE_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_dat <= '0;
    end else if (w_s1_adv) begin
      r_s1_vld <= iValid;
      if (iValid) begin
        r_s1_dat <= '{blk: iBlockIn, rnd: iRound};
      end
    end
  end

  // Output data only moves on a real S1->S2 transfer so an empty or stalled pipe holds oBlockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_dat <= '0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_dat <= '{blk: w_shift, rnd: r_s1_dat.rnd};
      end
    end
  end

  assign oValid    = r_s2_vld;
  assign oBlockout = r_s2_dat.blk;
  assign oRound    = r_s2_dat.rnd;

endmodule

// File: tb/tb_byte_sub_shift_row.sv
// Bench for byte_sub_shift_row: S-box derived from GF(2^8) inverse + affine map, ShiftRows from the s[r][c] rule.
module tb_byte_sub_shift_row;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iValid;
  logic         oReady;
  logic [127:0] iBlockIn;
  logic [3:0]   iRound;
  logic         oValid;
  logic         iReady;
  logic [127:0] oBlockout;
  logic [3:0]   oRound;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_blk_q [$];
  logic [3:0]   exp_rnd_q [$];

  always #5 clk = ~clk;

  byte_sub_shift_row dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iValid    (iValid),
    .oReady    (oReady),
    .iBlockIn  (iBlockIn),
    .iRound    (iRound),
    .oValid    (oValid),
    .iReady    (iReady),
    .oBlockout (oBlockout),
    .oRound    (oRound)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_blk(input logic [127:0] in);
    logic [7:0]   st [4][4];
    logic [127:0] out;
    out = '0;
    for (int k = 0; k < 16; k++) st[k % 4][k / 4] = sbox_ref[in[127-8*k -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        out[127-8*(4*c+r) -: 8] = st[r][(c + r) % 4];
    return out;
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_exp();
    exp_blk_q.push_back(ref_blk(iBlockIn));
    exp_rnd_q.push_back(iRound);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iValid = 1'b0; iReady = 1'b0; iBlockIn = '0; iRound = '0;
    #3;
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL reset_ovalid: got %b want 0", oValid); end
    total++; if (oBlockout !== 128'h0) begin bad++; $display("FAIL reset_oblock: got %h want 0", oBlockout); end
    total++; if (oRound !== 4'h0) begin bad++; $display("FAIL reset_oround: got %h want 0", oRound); end
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (oReady !== 1'b1) begin bad++; $display("FAIL reset_oready: got %b want 1", oReady); end
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL reset_ovalid_after: got %b want 0", oValid); end
  endtask

  task automatic test_fips_vector();
    iValid = 1'b1; iBlockIn = 128'h193de3bea0f4e22b9ac68d2ae9f84808; iRound = 4'd1; iReady = 1'b1;
    @(negedge clk);
    total++; if (oReady !== 1'b1) begin bad++; $display("FAIL fips_oready: got %b want 1", oReady); end
    @(posedge clk); #1;
    iValid = 1'b0;
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL fips_early: got %b want 0", oValid); end
    @(posedge clk); #1;
    total++;
    if (oValid !== 1'b1 || oBlockout !== 128'hd4bf5d30e0b452aeb84111f11e2798e5 || oRound !== 4'd1) begin
      bad++;
      $display("FAIL fips_out: got v=%b %h r=%0d want v=1 d4bf5d30e0b452aeb84111f11e2798e5 r=1", oValid, oBlockout, oRound);
    end
    @(posedge clk); #1;
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL fips_drain: got %b want 0", oValid); end
  endtask

  task automatic test_const_blocks();
    logic [127:0] ins  [2];
    logic [127:0] exps [2];
    logic [3:0]   rnds [2];
    ins[0] = 128'h0;  exps[0] = {16{8'h63}}; rnds[0] = 4'd0;
    ins[1] = '1;      exps[1] = {16{8'h16}}; rnds[1] = 4'd15;
    for (int i = 0; i < 2; i++) begin
      iValid = 1'b1; iBlockIn = ins[i]; iRound = rnds[i]; iReady = 1'b1;
      @(posedge clk); #1;
      iValid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (oValid !== 1'b1 || oBlockout !== exps[i] || oRound !== rnds[i]) begin
        bad++;
        $display("FAIL const_%0d: got v=%b %h r=%0d want v=1 %h r=%0d", i, oValid, oBlockout, oRound, exps[i], rnds[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    int outs;
    int first;
    int last;
    sent = 0; outs = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 40 && outs < 10; cyc++) begin
      iReady = 1'b1;
      iValid = (sent < 10);
      if (iValid) begin iBlockIn = rand_blk(); iRound = 4'(sent + 1); end
      @(negedge clk);
      if (iValid) begin
        total++; if (oReady !== 1'b1) begin bad++; $display("FAIL b2b_oready: cyc=%0d got %b want 1", cyc, oReady); end
        if (oReady) begin push_exp(); sent++; end
      end
      if (oValid && iReady) begin
        total++;
        if (exp_blk_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra: got %h want no output", oBlockout);
        end else begin
          if (oBlockout !== exp_blk_q[0] || oRound !== exp_rnd_q[0] || oRound !== 4'(outs + 1)) begin
            bad++;
            $display("FAIL b2b_data: got %h r=%0d want %h r=%0d", oBlockout, oRound, exp_blk_q[0], outs + 1);
          end
          void'(exp_blk_q.pop_front()); void'(exp_rnd_q.pop_front());
        end
        if (first < 0) first = cyc;
        last = cyc;
        outs++;
      end
      @(posedge clk); #1;
    end
    iValid = 1'b0;
    total++; if (outs !== 10) begin bad++; $display("FAIL b2b_count: got %0d want 10", outs); end
    total++; if (last - first !== 9) begin bad++; $display("FAIL b2b_span: got %0d want 9", last - first); end
  endtask

  task automatic test_stall();
    int acc;
    int outs;
    acc = 0; outs = 0;
    iReady = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      iValid = 1'b1; iBlockIn = rand_blk(); iRound = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (cyc >= 2) begin
        total++; if (oReady !== 1'b0) begin bad++; $display("FAIL stall_oready: cyc=%0d got %b want 0", cyc, oReady); end
        total++;
        if (oValid !== 1'b1 || oBlockout !== exp_blk_q[0] || oRound !== exp_rnd_q[0]) begin
          bad++;
          $display("FAIL stall_hold: cyc=%0d got v=%b %h r=%0d want v=1 %h r=%0d", cyc, oValid, oBlockout, oRound, exp_blk_q[0], exp_rnd_q[0]);
        end
      end
      if (iValid && oReady) begin push_exp(); acc++; end
      @(posedge clk); #1;
    end
    total++; if (acc !== 2) begin bad++; $display("FAIL stall_accepts: got %0d want 2", acc); end
    iValid = 1'b0; iReady = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (oValid && iReady) begin
        total++;
        if (exp_blk_q.size() == 0) begin
          bad++; $display("FAIL stall_dup: got %h want no output", oBlockout);
        end else begin
          if (oBlockout !== exp_blk_q[0] || oRound !== exp_rnd_q[0]) begin
            bad++; $display("FAIL stall_drain: got %h r=%0d want %h r=%0d", oBlockout, oRound, exp_blk_q[0], exp_rnd_q[0]);
          end
          void'(exp_blk_q.pop_front()); void'(exp_rnd_q.pop_front());
        end
        outs++;
      end
      @(posedge clk); #1;
    end
    total++; if (outs !== 2) begin bad++; $display("FAIL stall_outs: got %0d want 2", outs); end
  endtask

  task automatic test_reset_midstream();
    logic [127:0] blk;
    iReady = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      iValid = 1'b1; iBlockIn = rand_blk(); iRound = 4'($urandom_range(1, 10));
      @(posedge clk); #1;
    end
    #2; rst_n = 1'b0;
    #1;
    total++; if (oValid !== 1'b0) begin bad++; $display("FAIL rst_mid_ovalid: got %b want 0", oValid); end
    total++; if (oBlockout !== 128'h0 || oRound !== 4'h0) begin bad++; $display("FAIL rst_mid_data: got %h r=%0d want 0 r=0", oBlockout, oRound); end
    exp_blk_q.delete(); exp_rnd_q.delete();
    iValid = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (oReady !== 1'b1 || oValid !== 1'b0) begin bad++; $display("FAIL rst_mid_release: got rdy=%b v=%b want rdy=1 v=0", oReady, oValid); end
    blk = rand_blk();
    iValid = 1'b1; iBlockIn = blk; iRound = 4'd7; iReady = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (oValid !== 1'b1 || oBlockout !== ref_blk(blk) || oRound !== 4'd7) begin
      bad++; $display("FAIL rst_mid_next: got v=%b %h r=%0d want v=1 %h r=7", oValid, oBlockout, oRound, ref_blk(blk));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int sent;
    int got;
    logic         prev_stall;
    logic [127:0] prev_blk;
    logic [3:0]   prev_rnd;
    sent = 0; got = 0; prev_stall = 1'b0; prev_blk = '0; prev_rnd = '0;
    for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
      iValid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      if (iValid) begin iBlockIn = rand_blk(); iRound = 4'($urandom_range(0, 15)); end
      iReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if (oValid !== 1'b1 || oBlockout !== prev_blk || oRound !== prev_rnd) begin
          bad++; $display("FAIL rand_hold: got v=%b %h r=%0d want v=1 %h r=%0d", oValid, oBlockout, oRound, prev_blk, prev_rnd);
        end
      end
      if (iValid && oReady) begin push_exp(); sent++; end
      if (oValid && iReady) begin
        total++;
        if (exp_blk_q.size() == 0) begin
          bad++; $display("FAIL rand_extra: got %h want no output", oBlockout);
        end else begin
          if (oBlockout !== exp_blk_q[0] || oRound !== exp_rnd_q[0]) begin
            bad++; $display("FAIL rand_data: got %h r=%0d want %h r=%0d", oBlockout, oRound, exp_blk_q[0], exp_rnd_q[0]);
          end
          void'(exp_blk_q.pop_front()); void'(exp_rnd_q.pop_front());
        end
        got++;
      end
      prev_stall = oValid && !iReady;
      prev_blk   = oBlockout;
      prev_rnd   = oRound;
      @(posedge clk); #1;
    end
    iValid = 1'b0;
    total++; if (got !== 10000) begin bad++; $display("FAIL rand_count: got %0d want 10000", got); end
    total++; if (exp_blk_q.size() !== 0) begin bad++; $display("FAIL rand_leftover: got %0d want 0", exp_blk_q.size()); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_vector();
    test_const_blocks();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
